// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table,
// inactive output levels and digit count.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam logic [NUM_DIGITS-1:0] AN_OFF  = '0;
    localparam seg_t                  SEG_OFF = '0;

    // Segment a on bit 0 through g on bit 6; entry 15 listed first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment pattern, logical-high polarity.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit seven-segment driver clocked by an external one-hot
// phase; double-buffered display value, dead time and phase checking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DEAD_CYCLES = 2,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  phase,
    input  logic        data_valid,
    input  logic [15:0] data,
    output logic        data_ready,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        phase_err
);

    localparam int            DW        = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);

    logic [15:0]           shadow_q, shadow_d;
    logic [15:0]           pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic [3:0]            prev_phase_q, prev_phase_d;
    logic [DW-1:0]         dead_q, dead_d;
    logic                  phase_err_q, phase_err_d;
    logic [3:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    logic                  xfer;
    logic                  boundary;
    logic                  phase_chg;
    logic                  phase_ok;
    logic [1:0]            dig_idx;
    logic [3:0]            nib;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] nib_zero;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  upper_zero;

    assign data_ready = ~pend_full_q & ~rst;
    assign xfer       = data_valid & data_ready;
    assign phase_ok   = $onehot(phase);
    assign phase_chg  = (phase != prev_phase_q);
    assign boundary   = (phase == 4'b0001) && (prev_phase_q != 4'b0001);

    // Pending can only be full or accepting in a given cycle, never both,
    // so the boundary move and a new capture never collide.
    always_comb begin
        shadow_d    = shadow_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (boundary && pend_full_q) begin
            shadow_d    = pend_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_d      = data;
            pend_full_d = 1'b1;
        end
    end

    always_comb begin
        prev_phase_d = phase;
        phase_err_d  = phase_err_q | ~phase_ok;
        if (phase_chg) begin
            dead_d = DEAD_LOAD;
        end else if (dead_q != '0) begin
            dead_d = dead_q - DW'(1);
        end else begin
            dead_d = dead_q;
        end
    end

    always_comb begin
        dig_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (phase[i]) dig_idx = 2'(i);
        end
    end

    // Digits are taken from the next shadow value so that, with no dead
    // time, digit 0 of a new frame already shows the freshly moved value.
    assign nib = shadow_d[{dig_idx, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    always_comb begin
        nib_zero   = '0;
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib_zero[i] = (shadow_d[4*i +: 4] == 4'h0);
        end
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero & nib_zero[k];
            lz_blank[k] = upper_zero;
        end
    end

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (phase_ok && (dead_d == '0)) begin
            an_d  = phase;
            seg_d = (blank_lz && lz_blank[dig_idx]) ? SEG_OFF : dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            prev_phase_q <= '0;
            dead_q       <= DEAD_LOAD;
            phase_err_q  <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
        end else begin
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            prev_phase_q <= prev_phase_d;
            dead_q       <= dead_d;
            phase_err_q  <= phase_err_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an        = ACTIVE_LOW ? ~an_q  : an_q;
    assign seg       = ACTIVE_LOW ? ~seg_q : seg_q;
    assign phase_err = phase_err_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a D=2 active-low instance and a D=0 active-high
// instance share stimulus; a frame-level model is compared every cycle.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  phase;
    logic        data_valid;
    logic [15:0] data;
    logic        blank_lz;

    logic        rdy2, rdy0, err2, err0;
    logic [3:0]  an2, an0;
    logic [6:0]  seg2, seg0;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DEAD_CYCLES(2), .ACTIVE_LOW(1'b1)) u2 (
        .clk(clk), .rst(rst), .phase(phase), .data_valid(data_valid), .data(data),
        .data_ready(rdy2), .blank_lz(blank_lz), .an(an2), .seg(seg2), .phase_err(err2)
    );

    seg7_scan_driver #(.DEAD_CYCLES(0), .ACTIVE_LOW(1'b0)) u0 (
        .clk(clk), .rst(rst), .phase(phase), .data_valid(data_valid), .data(data),
        .data_ready(rdy0), .blank_lz(blank_lz), .an(an0), .seg(seg0), .phase_err(err0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction

    // Model: a frame value, a one-deep pending slot, and the number of edges
    // since the phase last changed; outputs follow from those directly.
    logic [15:0] m_shadow, m_pend;
    bit          m_full, m_err, m_bnd, m_acc, m_ok;
    logic [3:0]  m_prev;
    int          m_since, m_idx;
    logic [6:0]  m_glyph;
    logic [3:0]  e2_an, e0_an, x2_an;
    logic [6:0]  e2_seg, e0_seg, x2_seg;

    always @(posedge clk) begin
        if (rst) begin
            m_shadow = '0; m_full = 0; m_prev = '0; m_since = 0; m_err = 0;
            e2_an = '0; e2_seg = '0; e0_an = '0; e0_seg = '0;
        end else begin
            m_bnd = (phase == 4'b0001) && (m_prev != 4'b0001);
            m_acc = data_valid && !m_full;
            if (m_bnd && m_full) begin m_shadow = m_pend; m_full = 0; end
            if (m_acc) begin m_pend = data; m_full = 1; end
            m_ok = ($countones(phase) == 1);
            if (!m_ok) m_err = 1;
            if (phase != m_prev) m_since = 0;
            else if (m_since < 1000) m_since++;
            m_prev = phase;
            m_idx = 0;
            for (int i = 0; i < 4; i++) if (phase[i]) m_idx = i;
            m_glyph = hex7(m_shadow[4*m_idx +: 4]);
            if (blank_lz && m_idx > 0 && (m_shadow >> (4*m_idx)) == 16'h0) m_glyph = 7'h00;
            e0_an  = m_ok ? phase : 4'h0;
            e0_seg = m_ok ? m_glyph : 7'h00;
            e2_an  = (m_ok && m_since >= 2) ? phase : 4'h0;
            e2_seg = (m_ok && m_since >= 2) ? m_glyph : 7'h00;
        end
        #1;
        x2_an  = ~e2_an;
        x2_seg = ~e2_seg;
        chk("model_an_d2",   an2,  x2_an);
        chk("model_seg_d2",  seg2, x2_seg);
        chk("model_an_d0",   an0,  e0_an);
        chk("model_seg_d0",  seg0, e0_seg);
        chk("model_rdy_d2",  rdy2, !m_full && !rst);
        chk("model_rdy_d0",  rdy0, !m_full && !rst);
        chk("model_err_d2",  err2, m_err);
        chk("model_err_d0",  err0, m_err);
    end

    // One frame at 8 cycles per digit; checks dark first cycle and steady glyph
    // on the D=2 active-low instance. exp holds logical patterns, digit 3 first.
    task automatic frame_chk(input logic [3:0][6:0] exp, input string nm);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] ea;
            logic [6:0] es;
            phase = 4'(1 << d);
            @(negedge clk);
            chk({nm, "_dark"}, an2, 4'hF);
            repeat (7) @(negedge clk);
            ea = ~(4'(1 << d));
            es = ~exp[d];
            chk({nm, "_an"}, an2, ea);
            chk({nm, "_seg"}, seg2, es);
        end
    endtask

    initial begin
        rst = 1'b1; phase = 4'b0001; data_valid = 1'b0; data = '0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an",  an2,  4'hF);
        chk("rst_seg", seg2, 7'h7F);
        chk("rst_rdy", rdy2, 1'b0);
        chk("rst_an_hi", an0, 4'h0);
        chk("rst_err", err2, 1'b0);

        // Release into a boundary with pending empty and data offered.
        rst = 1'b0; data_valid = 1'b1; data = 16'h12AF;
        #1 chk("rdy_after_rst", rdy2, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        chk("rdy_after_load", rdy2, 1'b0);
        repeat (6) @(negedge clk);
        chk("f0_old_an",  an2,  4'hE);
        chk("f0_old_seg", seg2, 7'h40);
        for (int d = 1; d < 4; d++) begin
            phase = 4'(1 << d);
            repeat (8) @(negedge clk);
        end
        frame_chk({7'h06, 7'h5B, 7'h77, 7'h71}, "f1_12af");
        chk("rdy_after_bnd", rdy2, 1'b1);

        // Back-to-back: 1111 accepted, 2222 held until the next boundary.
        fork
            frame_chk({7'h06, 7'h5B, 7'h77, 7'h71}, "f2_12af");
            begin
                repeat (2) @(negedge clk);
                data_valid = 1'b1; data = 16'h1111;
                @(negedge clk);
                data = 16'h2222;
                @(negedge clk);
                chk("b2b_held", rdy2, 1'b0);
            end
        join
        fork
            frame_chk({7'h06, 7'h06, 7'h06, 7'h06}, "f3_1111");
            begin
                repeat (2) @(negedge clk);
                data_valid = 1'b0;
            end
        join
        frame_chk({7'h5B, 7'h5B, 7'h5B, 7'h5B}, "f4_2222");

        blank_lz = 1'b1;
        data_valid = 1'b1; data = 16'h0070;
        @(negedge clk);
        data_valid = 1'b0;
        frame_chk({7'h00, 7'h00, 7'h07, 7'h3F}, "lz_0070");
        data_valid = 1'b1; data = 16'h0000;
        @(negedge clk);
        data_valid = 1'b0;
        frame_chk({7'h00, 7'h00, 7'h00, 7'h3F}, "lz_0000");
        blank_lz = 1'b0;

        phase = 4'b0110;
        @(negedge clk);
        chk("bad_an_lo", an2, 4'hF);
        chk("bad_an_hi", an0, 4'h0);
        chk("bad_err",   err2, 1'b1);
        frame_chk({7'h3F, 7'h3F, 7'h3F, 7'h3F}, "bad_resume");
        chk("bad_sticky", err2, 1'b1);

        // No dead time: new digit 0 visible right after the boundary edge.
        data_valid = 1'b1; data = 16'h0005;
        @(negedge clk);
        data_valid = 1'b0;
        phase = 4'b0001;
        @(negedge clk);
        chk("d0_bnd_an",  an0,  4'b0001);
        chk("d0_bnd_seg", seg0, 7'h6D);
        phase = 4'b0010;
        @(negedge clk);
        chk("d0_chg_an",  an0,  4'b0010);
        chk("d0_chg_seg", seg0, 7'h3F);
        repeat (7) @(negedge clk);
        phase = 4'b0100; repeat (8) @(negedge clk);
        phase = 4'b1000; repeat (8) @(negedge clk);
        fork
            frame_chk({7'h3F, 7'h3F, 7'h3F, 7'h6D}, "bnd_load_0005");
            begin
                data_valid = 1'b1; data = 16'h0009;
                @(negedge clk);
                data_valid = 1'b0;
            end
        join
        frame_chk({7'h3F, 7'h3F, 7'h3F, 7'h6F}, "bnd_load_0009");

        // Mid-frame reset discards pending and blanks.
        phase = 4'b0001;
        repeat (3) @(negedge clk);
        data_valid = 1'b1; data = 16'hABCD;
        @(negedge clk);
        data_valid = 1'b0;
        phase = 4'b0010;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_an",  an2,  4'hF);
        chk("mid_rst_rdy", rdy2, 1'b0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        phase = 4'b0100; repeat (8) @(negedge clk);
        phase = 4'b1000; repeat (8) @(negedge clk);
        frame_chk({7'h3F, 7'h3F, 7'h3F, 7'h3F}, "post_rst_a");
        frame_chk({7'h3F, 7'h3F, 7'h3F, 7'h3F}, "post_rst_b");
        chk("post_rst_err", err2, 1'b0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
